// File: rtl/valve_pump_seq.sv
// valve_pump_seq
//   Peristaltic pump sequencer for a chain of NUM_VALVES series valves. Drives
//   a rotating close pattern (CLOSE_MASK rotated by the step index) onto the
//   valve air_in lines. Each step lasts dwell+1 clocks, and one pump cycle is
//   NUM_VALVES steps. A run lasts pump_count cycles, or runs until stop when
//   pump_count is 0.
//
//   Optional build macro VALVE_PUMP_DEADTIME_EN inserts a one-clock all-closed
//   slot between consecutive steps.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   run request, honoured only in IDLE
//   stop         in   early-termination request, honoured only in RUN
//   dir          in   0 = rotate left (forward), 1 = rotate right; latched on start
//   dwell_cycles in   extra clocks per step; latched on start
//   pump_count   in   cycles to run, 0 = continuous; latched on start
//   air_out      out  valve pattern, bit i drives valve i (1 = closed)
//   phase        out  current step index
//   busy         out  high while running
//   done         out  one-clock completion / stop pulse
module valve_pump_seq #(
  parameter int                    NUM_VALVES = 3,
  parameter logic [NUM_VALVES-1:0] CLOSE_MASK = 3'b011,
  parameter int                    DWELL_W    = 8,
  parameter int                    COUNT_W    = 8,
  parameter int                    PHASE_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic [DWELL_W-1:0]    dwell_cycles,
  input  logic [COUNT_W-1:0]    pump_count,
  output logic [NUM_VALVES-1:0] air_out,
  output logic [PHASE_W-1:0]    phase,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [NUM_VALVES-1:0] ALL_CLOSED = '1;
  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(NUM_VALVES - 1);

  // Rotation within NUM_VALVES bits via a doubled copy of the mask.
  function automatic logic [NUM_VALVES-1:0] rot_pattern(input logic [PHASE_W-1:0] sh,
                                                        input logic rev);
    logic [2*NUM_VALVES-1:0] dbl;
    dbl = {CLOSE_MASK, CLOSE_MASK};
    if (rev) begin
      dbl = dbl >> sh;
      return dbl[NUM_VALVES-1:0];
    end
    dbl = dbl << sh;
    return dbl[2*NUM_VALVES-1:NUM_VALVES];
  endfunction

  logic [1:0]            state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [COUNT_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic                  stop_q, stop_d;
  logic [NUM_VALVES-1:0] air_q, air_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dir_q, dir_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [COUNT_W-1:0]    count_q, count_d;
`ifdef VALVE_PUMP_DEADTIME_EN
  logic                  dead_q, dead_d;
`endif

  logic                  term;
  logic                  wrap;
  logic [PHASE_W-1:0]    next_phase;
  logic [COUNT_W-1:0]    cyc_inc;
  logic                  count_hit;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    dwell_cnt_d = dwell_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    stop_d      = stop_q;
    air_d       = air_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dir_d       = dir_q;
    dwell_d     = dwell_q;
    count_d     = count_q;
`ifdef VALVE_PUMP_DEADTIME_EN
    dead_d      = dead_q;
`endif

    term       = (dwell_cnt_q == dwell_q);
    wrap       = (phase_q == LAST_PHASE);
    next_phase = wrap ? '0 : phase_q + PHASE_W'(1);
    cyc_inc    = cyc_cnt_q + COUNT_W'(1);
    // Continuous mode never hits: the counter just wraps.
    count_hit  = (count_q != '0) && (cyc_inc == count_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          dir_d       = dir;
          dwell_d     = dwell_cycles;
          count_d     = pump_count;
          phase_d     = '0;
          dwell_cnt_d = '0;
          cyc_cnt_d   = '0;
          stop_d      = 1'b0;
          busy_d      = 1'b1;
          air_d       = CLOSE_MASK;
`ifdef VALVE_PUMP_DEADTIME_EN
          dead_d      = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (stop) stop_d = 1'b1;
`ifdef VALVE_PUMP_DEADTIME_EN
        // Dead slot: phase still shows the outgoing step; load the next one now.
        if (dead_q) begin
          dead_d  = 1'b0;
          phase_d = next_phase;
          air_d   = rot_pattern(next_phase, dir_q);
        end else
`endif
        if (!term) begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end else begin
          dwell_cnt_d = '0;
          if (wrap) cyc_cnt_d = cyc_inc;
          // A stop seen on the terminal clock itself still ends this step.
          if (stop_q || stop || (wrap && count_hit)) begin
            state_d = S_FINISH;
            air_d   = ALL_CLOSED;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            phase_d = '0;
          end else begin
`ifdef VALVE_PUMP_DEADTIME_EN
            dead_d  = 1'b1;
            air_d   = ALL_CLOSED;
`else
            phase_d = next_phase;
            air_d   = rot_pattern(next_phase, dir_q);
`endif
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        air_d   = ALL_CLOSED;
        busy_d  = 1'b0;
        phase_d = '0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      dwell_cnt_q <= '0;
      cyc_cnt_q   <= '0;
      stop_q      <= 1'b0;
      air_q       <= ALL_CLOSED;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef VALVE_PUMP_DEADTIME_EN
      dead_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      dwell_cnt_q <= dwell_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stop_q      <= stop_d;
      air_q       <= air_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef VALVE_PUMP_DEADTIME_EN
      dead_q      <= dead_d;
`endif
    end
  end

  // Run configuration, only meaningful while busy
  always_ff @(posedge clk) begin
    dir_q   <= dir_d;
    dwell_q <= dwell_d;
    count_q <= count_d;
  end

  assign air_out = air_q;
  assign phase   = phase_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/valve_pump_seq.md
Name: valve_pump_seq

Overview:
- Parametrised peristaltic pump controller for the microfluidic valve library.
- Drives the air_in control lines of NUM_VALVES series valves with a rotating close pattern, moving fluid one step per pattern advance.
- Adds direction, programmable dwell, cycle counting and stop handling, none of which the plain valve wrapper provides.
- Sits between the off-chip pneumatic controller interface and a chain of valve instances.

Parameters:
- NUM_VALVES, 3, valves in the pump chain (>=2); one pump cycle = NUM_VALVES steps.
- CLOSE_MASK, 3'b011, NUM_VALVES-bit step-0 pattern; 1 = pressurised (valve closed).
- DWELL_W, 8, width of dwell_cycles.
- COUNT_W, 8, width of pump_count and the cycle counter.
- PHASE_W, 2, width of phase; must satisfy 2**PHASE_W >= NUM_VALVES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pump run; sampled in IDLE only.
- stop  in  1  request early termination; sampled in RUN only.
- dir  in  1  0 = forward (rotate pattern left), 1 = reverse (rotate right); latched on start.
- dwell_cycles  in  DWELL_W  extra clocks each step is held; a step lasts dwell+1 clocks; latched on start.
- pump_count  in  COUNT_W  full cycles to run; 0 = continuous until stop; latched on start.
- air_out  out  NUM_VALVES  valve control pattern; bit i drives valve i air_in.
- phase  out  PHASE_W  current step index, 0..NUM_VALVES-1.
- busy  out  1  high while the sequence is running.
- done  out  1  one-clock pulse on completion or stop.

Behaviour:
- All outputs are registered.
- Reset values: air_out = all ones (all valves closed, safe), phase = 0, busy = 0, done = 0, FSM = IDLE, counters = 0.
- FSM states: IDLE, RUN, FINISH.
- IDLE -> RUN: start = 1 at edge T.
  - At T+1: busy = 1, phase = 0, air_out = CLOSE_MASK.
  - dwell_cycles, pump_count and dir are captured at T.
- RUN step timing:
  - The dwell counter counts 0..dwell.
  - At terminal count, phase advances: NUM_VALVES-1 wraps to 0.
  - air_out = CLOSE_MASK rotated by phase positions within NUM_VALVES bits: left if dir = 0, right if dir = 1.
- Cycle counting:
  - The wrap from phase NUM_VALVES-1 to 0 increments the cycle counter.
  - If pump_count != 0 and the incremented count equals pump_count, go to FINISH instead of re-entering phase 0.
- Stop:
  - stop = 1 in RUN sets a sticky stop flag.
  - The current step completes its full dwell, then the FSM goes to FINISH without a partial next step.
  - stop in IDLE or FINISH is ignored.
- FINISH: one clock.
  - air_out = all ones, busy = 0, done = 1, phase = 0.
  - Next state is IDLE.
  - start is not accepted in FINISH.
- start while busy is ignored. Inputs are not re-latched.
- start and stop together in IDLE: start is accepted and stop is ignored. The stop flag is clear entering RUN.
- Continuous mode (pump_count = 0): the cycle counter wraps modulo 2**COUNT_W without terminating.
- Reset mid-run: immediate asynchronous return to reset values. No done pulse.
- Every step of a run with N cycles: busy is high for exactly N*NUM_VALVES*(dwell+1) clocks.

Optional Feature:
- Macro: VALVE_PUMP_DEADTIME_EN.
- Defined:
  - A one-clock dead-time slot is inserted between consecutive steps, including the wrap between cycles.
  - During this slot air_out = all ones and phase holds the outgoing step.
  - A stop request still ends at a step boundary; no dead-time slot precedes FINISH.
  - busy length becomes N*NUM_VALVES*(dwell+1) + (N*NUM_VALVES-1).
- Undefined: patterns switch directly step to step, with no all-closed slot.

Test Plan:
- Reset, then idle 5 clocks -> air_out = 3'b111, busy = 0, done = 0, phase = 0 throughout.
- start, dir = 0, dwell = 1, count = 2 -> air_out = 011,011,110,110,101,101, repeated once; busy high 12 clocks; then one clock of done = 1 with air_out = 111.
- start, dir = 1, dwell = 0, count = 1 -> air_out = 011,101,110 on three consecutive clocks; done on the 4th clock.
- start with count = 0, dwell = 2; assert stop in the 2nd clock of phase 1 of cycle 5 -> phase 1 completes its 3rd clock, then FINISH/done; a re-pulse of start during the run is ignored.
- Run with dwell = 3; assert rst mid-step -> air_out = 111 and busy = 0 immediately, with no done; a new start after reset runs normally from phase 0.
- With VALVE_PUMP_DEADTIME_EN defined: dir = 0, dwell = 0, count = 1 -> air_out = 011,111,110,111,101; then done.
